// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture path: FSM states, default
// counter width and its saturation value.
package pwm_pkg;

    typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

    localparam int CNT_W_DEF = 10;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/pwm_capture_if.sv
// Control and result bundle of pwm_capture. The master drives the PWM input
// and the enable; the slave (the capture block) returns measurements.
interface pwm_capture_if #(parameter int CNT_W = pwm_pkg::CNT_W_DEF);
    logic             ena_i;
    logic             pwm_i;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             valid_o;
    logic             overflow_o;
    logic             stuck_o;

    modport master (output ena_i, pwm_i,
                    input  period_o, high_o, valid_o, overflow_o, stuck_o);
    modport slave  (input  ena_i, pwm_i,
                    output period_o, high_o, valid_o, overflow_o, stuck_o);
endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Multi-flop synchronizer for an asynchronous single-bit input plus
// rise/fall pulses; both edges see the same latency.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic res_i,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk) begin
        if (res_i) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o =  s_o & ~s_d;
    assign fall_o = ~s_o &  s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture. Optional stuck-input detection is enabled
// by defining PWM_CAPTURE_STUCK_DETECT_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           res_i,
    pwm_capture_if.slave   bus
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_max(CNT_W));

    logic rise, fall;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, high_lat_q, high_lat_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic ovf_q, ovf_d, valid_q, valid_d, overflow_q, overflow_d;

`ifdef PWM_CAPTURE_STUCK_DETECT_EN
    logic s, stuck_q, stuck_d;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .res_i(res_i), .d_i(bus.pwm_i),
        .s_o(s), .rise_o(rise), .fall_o(fall)
    );
`else
    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .res_i(res_i), .d_i(bus.pwm_i),
        .s_o(), .rise_o(rise), .fall_o(fall)
    );
`endif

    always_ff @(posedge clk) begin
        if (res_i) begin
            state_q    <= ARM;
            cnt_q      <= '0;
            high_lat_q <= '0;
            ovf_q      <= 1'b0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_lat_q <= high_lat_d;
            ovf_q      <= ovf_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PWM_CAPTURE_STUCK_DETECT_EN
    always_ff @(posedge clk) begin
        if (res_i) stuck_q <= 1'b0;
        else       stuck_q <= stuck_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_lat_d = high_lat_q;
        ovf_d      = ovf_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
`ifdef PWM_CAPTURE_STUCK_DETECT_EN
        stuck_d    = stuck_q;
`endif
        cnt_inc    = (cnt_q == SAT) ? SAT : cnt_q + 1'b1;

        if (!bus.ena_i) begin
            state_d = ARM;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HIGH, LOW: begin
                    if (state_q == LOW && rise) begin
                        state_d    = HIGH;
                        period_d   = cnt_q;
                        high_d     = high_lat_q;
                        valid_d    = 1'b1;
                        overflow_d = ovf_q;
                        ovf_d      = 1'b0;
                        cnt_d      = CNT_W'(1);
`ifdef PWM_CAPTURE_STUCK_DETECT_EN
                        stuck_d    = 1'b0;
`endif
                    end else if (state_q == HIGH && fall) begin
                        state_d    = LOW;
                        high_lat_d = cnt_q;
                        cnt_d      = cnt_inc;
                        ovf_d      = ovf_q | (cnt_inc == SAT);
`ifdef PWM_CAPTURE_STUCK_DETECT_EN
                    end else if (cnt_q == SAT) begin
                        // no edge for a full counter range: report level and re-arm
                        state_d    = ARM;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        period_d   = '0;
                        high_d     = s ? SAT : '0;
                        valid_d    = 1'b1;
                        overflow_d = 1'b1;
                        stuck_d    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | (cnt_inc == SAT);
                    end
                end
                default: state_d = ARM;
            endcase
        end
    end

    assign bus.period_o   = period_q;
    assign bus.high_o     = high_q;
    assign bus.valid_o    = valid_q;
    assign bus.overflow_o = overflow_q;
`ifdef PWM_CAPTURE_STUCK_DETECT_EN
    assign bus.stuck_o    = stuck_q;
`else
    assign bus.stuck_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table vectors, hand sequences for reset/enable/overflow
// corners and randomized waveforms scored against an edge-timestamp model.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W = 10;
    localparam int SAT   = 2**CNT_W - 1;

    typedef struct { int p; int h; bit o; } cap_t;
    typedef struct { int p; int h; bit o; bit s; } got_t;
    typedef struct { int hi; int lo; int ep; int eh; bit eo; } vec_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;

    pwm_capture_if #(.CNT_W(CNT_W)) bus ();
    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (.clk(clk), .res_i(res), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: timestamps of input edges, one capture per full period
    bit   armed = 0, m_en = 0, model_on = 1;
    int   lr = 0, lf = 0;
    cap_t exp_q[$];
    cap_t m_last = '{0, 0, 0};
    got_t got_q[$];
    int   vq[$];
    cap_t mon_e;

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pwm(input logic lvl);
        cap_t c;
        if (lvl && !bus.pwm_i) begin
            if (m_en) begin
                if (armed) begin
                    c.p = sat(cyc - lr);
                    c.h = sat(lf - lr);
                    c.o = (cyc - lr) >= SAT;
                    m_last = c;
                    if (model_on) exp_q.push_back(c);
                end
                armed = 1;
                lr = cyc;
            end
        end else if (!lvl && bus.pwm_i) begin
            lf = cyc;
        end
        bus.pwm_i = lvl;
    endtask

    task automatic drive(input logic lvl, input int n);
        set_pwm(lvl);
        repeat (n) tick();
    endtask

    task automatic set_ena(input logic v);
        bus.ena_i = v;
        m_en = v;
        if (!v) armed = 0;
    endtask

    task automatic do_reset(input string nm);
        res = 1'b1;
        armed = 0;
        m_last = '{0, 0, 0};
        repeat (3) tick();
        chk({nm, "_period"}, int'(bus.period_o), 0);
        chk({nm, "_high"}, int'(bus.high_o), 0);
        chk({nm, "_valid"}, int'(bus.valid_o), 0);
        chk({nm, "_ovf"}, int'(bus.overflow_o), 0);
        chk({nm, "_stuck"}, int'(bus.stuck_o), 0);
        res = 1'b0;
    endtask

    task automatic drain(input string nm);
        drive(1'b0, 12);
        chk({nm, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!res && bus.valid_o) begin
            got_q.push_back('{int'(bus.period_o), int'(bus.high_o), bus.overflow_o, bus.stuck_o});
            vq.push_back(cyc);
            if (model_on) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mdl_period", int'(bus.period_o), mon_e.p);
                    chk("mdl_high", int'(bus.high_o), mon_e.h);
                    chk("mdl_ovf", int'(bus.overflow_o), int'(mon_e.o));
                    chk("mdl_stuck", int'(bus.stuck_o), 0);
                end
            end
        end
    end

    vec_t tbl[7];

    initial begin
        int hi, lo;
        tbl[0] = '{3, 7, 10, 3, 0};
        tbl[1] = '{1, 255, 256, 1, 0};
        tbl[2] = '{255, 1, 256, 255, 0};
        tbl[3] = '{12, 8, 20, 12, 0};
        tbl[4] = '{1, 1, 2, 1, 0};
        tbl[5] = '{511, 511, 1022, 511, 0};
        tbl[6] = '{1, 1021, 1022, 1, 0};

        bus.pwm_i = 1'b0;
        bus.ena_i = 1'b0;
        set_ena(1'b1);
        do_reset("rst");

        // table vectors: one period per entry, each reported at the following rise
        drive(1'b0, 10);
        drive(1'b1, 4);
        drive(1'b0, 6);
        got_q.delete();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].hi);
            drive(1'b0, tbl[i].lo);
        end
        drive(1'b1, 5);
        drain("tbl");
        chk("tbl_count", got_q.size(), 8);
        for (int i = 0; i < 7 && i + 1 < got_q.size(); i++) begin
            chk($sformatf("tbl%0d_period", i), got_q[i+1].p, tbl[i].ep);
            chk($sformatf("tbl%0d_high", i), got_q[i+1].h, tbl[i].eh);
            chk($sformatf("tbl%0d_ovf", i), int'(got_q[i+1].o), int'(tbl[i].eo));
        end

        // generator loopback: reload=9 set=0 clr=3 -> high 3, low 7
        do_reset("lb_rst");
        drive(1'b0, 5);
        vq.delete();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        drain("lb");
        chk("lb_count", vq.size(), 6);
        for (int i = 1; i < vq.size(); i++) chk("lb_spacing", vq[i] - vq[i-1], 10);

`ifndef PWM_CAPTURE_STUCK_DETECT_EN
        // saturation across a 1200-cycle period, then a clean 20-cycle period
        do_reset("ov_rst");
        drive(1'b0, 5);
        got_q.delete();
        drive(1'b1, 600);
        drive(1'b0, 600);
        drive(1'b1, 10);
        drive(1'b0, 10);
        chk("ov_sticky", int'(bus.overflow_o), 1);
        drive(1'b1, 5);
        drain("ov");
        chk("ov_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("ov_period", got_q[0].p, 1023);
            chk("ov_flag", int'(got_q[0].o), 1);
            chk("ov_next_period", got_q[1].p, 20);
            chk("ov_next_flag", int'(got_q[1].o), 0);
        end
`else
        // input stuck high after arming: forced report, then normal recovery
        do_reset("st_rst");
        drive(1'b0, 5);
        model_on = 0;
        got_q.delete();
        drive(1'b1, 1100);
        drive(1'b0, 10);
        drive(1'b1, 5);
        drive(1'b0, 5);
        drive(1'b1, 5);
        drive(1'b0, 5);
        drive(1'b1, 3);
        drive(1'b0, 12);
        chk("st_count", got_q.size(), 3);
        if (got_q.size() >= 3) begin
            chk("st_period", got_q[0].p, 0);
            chk("st_high", got_q[0].h, SAT);
            chk("st_ovf", int'(got_q[0].o), 1);
            chk("st_flag", int'(got_q[0].s), 1);
            chk("st_clr_flag", int'(got_q[1].s), 0);
            chk("st_clr_period", got_q[1].p, 10);
            chk("st_clr_high", got_q[1].h, 5);
        end
        exp_q.delete();
        model_on = 1;
`endif

        // reset in the middle of a low phase
        do_reset("rm_rst0");
        drive(1'b0, 5);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5);
            drive(1'b0, 15);
        end
        drive(1'b1, 5);
        drive(1'b0, 8);
        chk("rm_pre_pending", exp_q.size(), 0);
        do_reset("rm_mid");
        drive(1'b0, 4);
        vq.delete();
        drive(1'b1, 5);
        drive(1'b0, 15);
        chk("rm_no_valid_arm", vq.size(), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5);
            drive(1'b0, 15);
        end
        drain("rm");
        chk("rm_count", vq.size(), 3);

        // enable dropped for 50 cycles inside a low phase
        do_reset("en_rst");
        drive(1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 30);
        end
        drive(1'b1, 10);
        drive(1'b0, 5);
        set_ena(1'b0);
        drive(1'b0, 25);
        chk("en_hold_period", int'(bus.period_o), m_last.p);
        chk("en_hold_high", int'(bus.high_o), m_last.h);
        chk("en_hold_ovf", int'(bus.overflow_o), int'(m_last.o));
        drive(1'b1, 10);
        drive(1'b0, 15);
        chk("en_hold_period2", int'(bus.period_o), m_last.p);
        set_ena(1'b1);
        drive(1'b0, 15);
        vq.delete();
        drive(1'b1, 10);
        drive(1'b0, 30);
        chk("en_no_valid_arm", vq.size(), 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 10);
            drive(1'b0, 30);
        end
        drain("en");
        chk("en_count", vq.size(), 2);

        // randomized waveforms
        do_reset("rnd_rst");
        drive(1'b0, 5);
        for (int i = 0; i < 40; i++) begin
            hi = $urandom_range(60, 1);
            lo = $urandom_range(60, 1);
            if ($urandom_range(7, 0) == 0) hi = $urandom_range(400, 100);
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
        drive(1'b1, 5);
        drain("rnd");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
